// File: rtl/cska_pkg.sv
// Shared types and default geometry for the sequential carry-skip adder/subtractor.
package cska_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_BLK_W = 4;
    localparam int NBLK      = DEF_WIDTH / DEF_BLK_W;
    localparam int IDX_W     = (NBLK > 1) ? $clog2(NBLK) : 1;

endpackage

// File: rtl/cska_seq_subtractor_if.sv
// Operand and result handshake bundle between the issuing controller and the adder/subtractor.
interface cska_seq_subtractor_if
    import cska_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic             op_sub;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, op_sub, in1, in2, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, op_sub, in1, in2, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );

endinterface

// File: rtl/cska_block.sv
// One carry-skip block: BLK_W-bit ripple adder whose carry out bypasses the chain when all bits propagate.
module cska_block #(
    parameter int BLK_W = 4
) (
    input  logic [BLK_W-1:0] a,
    input  logic [BLK_W-1:0] b,
    input  logic             cin,
    output logic [BLK_W-1:0] s,
    output logic             cout
);
    logic [BLK_W-1:0] p;
    logic [BLK_W:0]   c;

    assign c[0] = cin;

    generate
        for (genvar gi = 0; gi < BLK_W; gi++) begin : g_bit
            assign p[gi]    = a[gi] ^ b[gi];
            assign s[gi]    = p[gi] ^ c[gi];
            assign c[gi+1]  = (a[gi] & b[gi]) | (p[gi] & c[gi]);
        end
    endgenerate

    // When every bit propagates the ripple carry equals cin anyway, so the skip is exact.
    assign cout = (&p) ? cin : c[BLK_W];

endmodule

// File: rtl/cska_seq_subtractor.sv
// Multi-cycle adder/subtractor: one carry-skip block of the operands is resolved per clock.
module cska_seq_subtractor
    import cska_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int BLK_W = DEF_BLK_W
) (
    input logic                   clk,
    input logic                   rst,
    cska_seq_subtractor_if.slave  bus
);
    localparam int NB = WIDTH / BLK_W;
    localparam int IW = (NB > 1) ? $clog2(NB) : 1;

    state_e           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry_q;
    logic [IW-1:0]    idx_q;
    logic [IW-1:0]    idx_d;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;

    logic [BLK_W-1:0] blk_a;
    logic [BLK_W-1:0] blk_b;
    logic [BLK_W-1:0] blk_s;
    logic             blk_cout;

    // Select the operand slice for the block currently being resolved.
    always_comb begin
        blk_a = '0;
        blk_b = '0;
        for (int i = 0; i < NB; i++) begin
            if (idx_q == IW'(i)) begin
                blk_a = a_q[i*BLK_W +: BLK_W];
                blk_b = b_q[i*BLK_W +: BLK_W];
            end
        end
        idx_d = idx_q + 1'b1;
    end

    cska_block #(.BLK_W(BLK_W)) u_block (
        .a    (blk_a),
        .b    (blk_b),
        .cin  (carry_q),
        .s    (blk_s),
        .cout (blk_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            idx_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        // Subtraction is A + ~B + 1: invert B now, the +1 enters as carry-in.
                        a_q        <= bus.in1;
                        b_q        <= bus.op_sub ? ~bus.in2 : bus.in2;
                        carry_q    <= bus.op_sub;
                        idx_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= RUN;
                    end
                end
                RUN: begin
                    for (int i = 0; i < NB; i++) begin
                        if (idx_q == IW'(i)) begin
                            sum_q[i*BLK_W +: BLK_W] <= blk_s;
                        end
                    end
                    carry_q <= blk_cout;
                    if (idx_q == IW'(NB - 1)) begin
                        cout_q      <= blk_cout;
                        ovf_q       <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                                       (blk_s[BLK_W-1] != a_q[WIDTH-1]);
                        out_valid_q <= 1'b1;
                        idx_q       <= '0;
                        state_q     <= DONE;
                    end else begin
                        idx_q <= idx_d;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_cska_seq_subtractor.sv
// Directed and randomized self-checking bench for the sequential carry-skip adder/subtractor.
module tb_cska_seq_subtractor;
    import cska_pkg::*;

    localparam int W = DEF_WIDTH;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cska_seq_subtractor_if #(.WIDTH(W)) bus ();

    cska_seq_subtractor #(.WIDTH(W), .BLK_W(DEF_BLK_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Waits for in_ready, presents operands for exactly the accepting edge, then scrambles inputs.
    task automatic start_op(input logic sub, input logic [W-1:0] a, input logic [W-1:0] b,
                            input string tag);
        int n;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk({tag, "_in_ready"}, W'(bus.in_ready), W'(1));
        bus.in_valid = 1'b1;
        bus.op_sub   = sub;
        bus.in1      = a;
        bus.in2      = b;
        step();
        bus.in_valid = 1'b0;
        bus.op_sub   = ~sub;
        bus.in1      = $urandom;
        bus.in2      = $urandom;
    endtask

    // Returns the number of edges after the accepting edge until out_valid is seen.
    task automatic wait_result(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (bus.out_valid !== 1'b1 && n < 20);
    endtask

    task automatic run_op(input logic sub, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] esum, input logic ecout, input logic eovf,
                          input string tag);
        int n;
        start_op(sub, a, b, tag);
        wait_result(n);
        chk({tag, "_latency"}, W'(n), W'(NBLK));
        chk({tag, "_sum"}, bus.sum, esum);
        chk({tag, "_cout"}, W'(bus.cout), W'(ecout));
        chk({tag, "_ovf"}, W'(bus.ovf), W'(eovf));
        $display("op %s sub=%0d a=%h b=%h sum=%h cout=%0d ovf=%0d lat=%0d",
                 tag, sub, a, b, bus.sum, bus.cout, bus.ovf, n);
        step();
        chk({tag, "_ov_drop"}, W'(bus.out_valid), W'(0));
        chk({tag, "_ir_back"}, W'(bus.in_ready), W'(1));
    endtask

    task automatic ref_model(input logic sub, input logic [W-1:0] a, input logic [W-1:0] b,
                             output logic [W-1:0] s, output logic co, output logic ov);
        logic [W:0] r;
        if (sub) begin
            r  = {1'b0, a} - {1'b0, b};
            co = ~r[W];
            ov = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
        end else begin
            r  = {1'b0, a} + {1'b0, b};
            co = r[W];
            ov = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
        end
        s = r[W-1:0];
    endtask

    initial begin
        int n;
        logic [W-1:0] ra, rb, rs, held;
        logic rsub, rco, rov;

        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.op_sub   = 1'b0;
        bus.in1      = '0;
        bus.in2      = '0;
        bus.out_ready = 1'b1;
        repeat (3) step();
        chk("rst_in_ready", W'(bus.in_ready), W'(1));
        chk("rst_out_valid", W'(bus.out_valid), W'(0));
        chk("rst_sum", bus.sum, '0);
        chk("rst_cout", W'(bus.cout), W'(0));
        chk("rst_ovf", W'(bus.ovf), W'(0));
        rst = 1'b0;
        step();

        run_op(1'b1, 32'h0000_0005, 32'h0000_0003, 32'h0000_0002, 1'b1, 1'b0, "sub_5_3");
        run_op(1'b1, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b1, "sub_min_1");
        run_op(1'b1, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, "sub_0_1");
        run_op(1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'hFFFF_FFFE, 1'b0, 1'b1, "add_max_max");
        run_op(1'b0, 32'h8000_0001, 32'h8000_0001, 32'h0000_0002, 1'b1, 1'b1, "add_neg_neg");
        run_op(1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, "add_wrap");

        // Back-pressure: result must hold while out_ready is low, in_valid ignored.
        bus.out_ready = 1'b0;
        start_op(1'b1, 32'h1234_5678, 32'h0000_1111, "hold");
        wait_result(n);
        chk("hold_latency", W'(n), W'(NBLK));
        chk("hold_sum", bus.sum, 32'h1234_4567);
        held = bus.sum;
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.in1      = $urandom;
            step();
            chk("hold_out_valid", W'(bus.out_valid), W'(1));
            chk("hold_in_ready", W'(bus.in_ready), W'(0));
            chk("hold_sum_stable", bus.sum, held);
            chk("hold_cout", W'(bus.cout), W'(1));
        end
        $display("op hold sum=%h held for 5 cycles", bus.sum);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        step();
        chk("hold_release_ov", W'(bus.out_valid), W'(0));
        chk("hold_release_ir", W'(bus.in_ready), W'(1));

        // Reset at the fourth RUN cycle aborts the operation.
        start_op(1'b0, 32'h0F0F_0F0F, 32'h1111_1111, "abort");
        repeat (3) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_in_ready", W'(bus.in_ready), W'(1));
        chk("abort_out_valid", W'(bus.out_valid), W'(0));
        chk("abort_sum", bus.sum, '0);
        for (int i = 0; i < 12; i++) begin
            step();
            chk("abort_no_valid", W'(bus.out_valid), W'(0));
        end
        $display("op abort reset mid-run, no result produced");
        run_op(1'b1, 32'h0000_0064, 32'h0000_0032, 32'h0000_0032, 1'b1, 1'b0, "after_abort");

        for (int k = 0; k < 1000; k++) begin
            ra   = $urandom;
            rb   = $urandom;
            rsub = 1'($urandom_range(0, 1));
            if (k % 8 == 0) rb = ~ra;
            ref_model(rsub, ra, rb, rs, rco, rov);
            run_op(rsub, ra, rb, rs, rco, rov, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
